// File: rtl/audio_sequencer.sv
// Transport controller: divides clk48 into sample/tick/beat strobes, applies swing to
// beat length and walks songpos between loop_start and loop_end.
//
// state | meaning
// STOP  | counters held, no strobes, waiting for run
// PLAY  | counters running, strobes generated
// PAUSE | counters and songpos frozen, resumes from the exact count
module audio_sequencer #(
  parameter int SAMPLE_DIV = 1024,
  parameter int TICK_LEN   = 256,
  parameter int BEAT_TICKS = 18,
  parameter int SWING      = 5
) (
  input  logic       clk48,
  input  logic       rst,
  input  logic       run,
  input  logic       restart,
  input  logic [7:0] loop_start,
  input  logic [7:0] loop_end,
  output logic       sample_stb,
  output logic       tick_stb,
  output logic       beat_stb,
  output logic [7:0] songpos,
  output logic [7:0] songpos_next,
  output logic [4:0] beat_div,
  output logic       playing
);

  localparam int SW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int TW = (TICK_LEN > 1) ? $clog2(TICK_LEN) : 1;
  localparam logic [SW-1:0] SAMP_LAST = SW'(SAMPLE_DIV - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_LEN - 1);
  localparam logic [4:0] LONG_M1  = 5'(BEAT_TICKS + SWING - 1);
  localparam logic [4:0] SHORT_M1 = 5'(BEAT_TICKS - SWING - 1);

  typedef enum logic [1:0] {ST_STOP, ST_PLAY, ST_PAUSE} state_t;

  state_t        state_q;
  logic [SW-1:0] samp_q;
  logic [TW-1:0] tick_q;
  logic [4:0]    beat_div_q;
  logic [7:0]    songpos_q;
  logic          first_q;
  logic          playing_q;
  logic [4:0]    beat_len_d;
  logic          counting;

  always_comb begin
    counting   = (state_q == ST_PLAY) && !restart;
    sample_stb = counting && (samp_q == SAMP_LAST);
    tick_stb   = sample_stb && (tick_q == TICK_LAST);
    beat_stb   = tick_stb && (beat_div_q == 5'd0);
    if (first_q || (songpos_q == loop_end)) songpos_next = loop_start;
    else                                    songpos_next = songpos_q + 8'd1;
    // odd positions get the long (swung) beat
    beat_len_d = songpos_next[0] ? LONG_M1 : SHORT_M1;
  end

  always_ff @(posedge clk48 or posedge rst) begin
    if (rst) begin
      state_q    <= ST_STOP;
      samp_q     <= '0;
      tick_q     <= '0;
      beat_div_q <= 5'd0;
      songpos_q  <= 8'd0;
      first_q    <= 1'b1;
      playing_q  <= 1'b0;
    end else if (restart) begin
      samp_q     <= '0;
      tick_q     <= '0;
      beat_div_q <= 5'd0;
      first_q    <= 1'b1;
      state_q    <= run ? ST_PLAY : ST_STOP;
      playing_q  <= run;
    end else begin
      case (state_q)
        ST_STOP: begin
          if (run) begin
            state_q   <= ST_PLAY;
            playing_q <= 1'b1;
          end
        end
        ST_PLAY: begin
          samp_q <= (samp_q == SAMP_LAST) ? '0 : samp_q + 1'b1;
          if (sample_stb) tick_q <= (tick_q == TICK_LAST) ? '0 : tick_q + 1'b1;
          if (beat_stb) begin
            songpos_q  <= songpos_next;
            beat_div_q <= beat_len_d;
            first_q    <= 1'b0;
          end else if (tick_stb) begin
            beat_div_q <= beat_div_q - 5'd1;
          end
          // a strobe on the run-drop cycle still completes before pausing
          if (!run) begin
            state_q   <= ST_PAUSE;
            playing_q <= 1'b0;
          end
        end
        ST_PAUSE: begin
          if (run) begin
            state_q   <= ST_PLAY;
            playing_q <= 1'b1;
          end
        end
        default: begin
          state_q   <= ST_STOP;
          playing_q <= 1'b0;
        end
      endcase
    end
  end

  assign songpos  = songpos_q;
  assign beat_div = beat_div_q;
  assign playing  = playing_q;

endmodule
